// File: rtl/seq_normalize.sv
// Iterative left-shift normalizer: one bit of shift per clock until the operand's
// leading bit (unsigned) or sign/next-bit boundary (signed) reaches the MSB.
module seq_normalize #(
  parameter int N_bits = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_bits-1:0]         d,
  input  logic                      arith,
  output logic                      busy,
  output logic                      done,
  output logic [N_bits-1:0]         d_norm,
  output logic [$clog2(N_bits)-1:0] shift_amount,
  output logic                      zero
);

  localparam int SW = $clog2(N_bits);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [N_bits-1:0] work_q, work_d;
  logic [SW-1:0]     count_q, count_d;
  logic              arith_q, arith_d;
  logic [N_bits-1:0] d_norm_q, d_norm_d;
  logic [SW-1:0]     shift_q, shift_d;
  logic              zero_q, zero_d;

  logic accept;
  logic is_zero;
  logic is_norm;
  logic at_limit;

  // A signed -1 is not a zero case: it shifts down to 100..0, so only 0 is.
  assign accept   = start && (state_q != SHIFT);
  assign is_zero  = (work_q == '0);
  assign is_norm  = arith_q ? (work_q[N_bits-1] ^ work_q[N_bits-2]) : work_q[N_bits-1];
  assign at_limit = (count_q == SW'(N_bits - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (is_zero || is_norm || at_limit) state_d = DONE;
      DONE:    state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  assign d_norm       = d_norm_q;
  assign shift_amount = shift_q;
  assign zero         = zero_q;

  // Datapath next-state: load on accept, one shift per SHIFT cycle, publish on exit.
  always_comb begin
    work_d   = work_q;
    count_d  = count_q;
    arith_d  = arith_q;
    d_norm_d = d_norm_q;
    shift_d  = shift_q;
    zero_d   = zero_q;
    if (accept) begin
      work_d  = d;
      count_d = '0;
      arith_d = arith;
    end else if (state_q == SHIFT) begin
      if (is_zero) begin
        d_norm_d = '0;
        shift_d  = '0;
        zero_d   = 1'b1;
      end else if (is_norm || at_limit) begin
        d_norm_d = work_q;
        shift_d  = count_q;
        zero_d   = 1'b0;
      end else begin
        work_d  = {work_q[N_bits-2:0], 1'b0};
        count_d = count_q + SW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q   <= '0;
      count_q  <= '0;
      arith_q  <= 1'b0;
      d_norm_q <= '0;
      shift_q  <= '0;
      zero_q   <= 1'b0;
    end else begin
      work_q   <= work_d;
      count_q  <= count_d;
      arith_q  <= arith_d;
      d_norm_q <= d_norm_d;
      shift_q  <= shift_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_seq_normalize.sv
// Self-checking bench for seq_normalize (N_bits=32): directed table, corner sequences,
// and randomized operations against a leading-bit-count reference model.
module tb_seq_normalize;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] d;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] d_norm;
  logic [4:0]  shift_amount;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prev_norm  = '0;
  int          prev_shift = 0;
  logic        prev_zero  = 1'b0;

  typedef struct {
    logic        a;
    logic [31:0] v;
    logic [31:0] en;
    int          es;
    logic        ez;
    int          el;
    int          gap;
  } vec_t;

  vec_t vecs[11];

  seq_normalize #(.N_bits(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .d            (d),
    .arith        (arith),
    .busy         (busy),
    .done         (done),
    .d_norm       (d_norm),
    .shift_amount (shift_amount),
    .zero         (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: shift = number of leading bits matching the reference bit (0 for
  // unsigned, the sign for signed), minus one when signed; operand 0 is the zero case.
  function automatic void model(input logic a, input logic [31:0] v,
                                output logic [31:0] n, output int s,
                                output logic z, output int lat);
    int   lead;
    logic refb;
    lead = 0;
    refb = a ? v[31] : 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i] != refb) break;
      lead++;
    end
    if (v == 32'h0) begin
      n = '0; s = 0; z = 1'b1; lat = 1;
    end else begin
      s   = a ? lead - 1 : lead;
      n   = v << s;
      z   = 1'b0;
      lat = s + 1;
    end
  endfunction

  // Called just after an edge; starts an op, checks busy/hold, waits for done.
  task automatic do_op(input logic a, input logic [31:0] v, input logic [31:0] en,
                       input int es, input logic ez, input int el, input string tag);
    int lat;
    start = 1'b1;
    arith = a;
    d     = v;
    @(posedge clk); #1;
    start = 1'b0;
    d     = $urandom;
    arith = 1'($urandom_range(0, 1));
    check({tag, " busy after accept"}, 64'(busy), 64'd1);
    check({tag, " d_norm held"}, 64'(d_norm), 64'(prev_norm));
    check({tag, " shift held"}, 64'(shift_amount), 64'(prev_shift));
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(el));
    check({tag, " d_norm"}, 64'(d_norm), 64'(en));
    check({tag, " shift_amount"}, 64'(shift_amount), 64'(es));
    check({tag, " zero"}, 64'(zero), 64'(ez));
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    prev_norm  = en;
    prev_shift = es;
    prev_zero  = ez;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle done low", 64'(done), 64'd0);
      check("idle busy low", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] rn;
    int          rs;
    logic        rz;
    int          rl;
    int          lat;

    vecs[0]  = '{1'b0, 32'h0000_0001, 32'h8000_0000, 31, 1'b0, 32, 1};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000,  0, 1'b0,  1, 1};
    vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0000_0000,  0, 1'b1,  1, 2};
    vecs[3]  = '{1'b1, 32'hFFFF_FFF0, 32'h8000_0000, 27, 1'b0, 28, 0};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 31, 1'b0, 32, 1};
    vecs[5]  = '{1'b1, 32'h0000_0003, 32'h6000_0000, 29, 1'b0, 30, 0};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'h0000_0000,  0, 1'b1,  1, 0};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'h8000_0000,  0, 1'b0,  1, 0};
    vecs[8]  = '{1'b0, 32'h4000_0000, 32'h8000_0000,  1, 1'b0,  2, 1};
    vecs[9]  = '{1'b1, 32'h4000_0000, 32'h4000_0000,  0, 1'b0,  1, 0};
    vecs[10] = '{1'b0, 32'h0001_0000, 32'h8000_0000, 15, 1'b0, 16, 1};

    rst = 1'b1; start = 1'b0; d = '0; arith = 1'b0;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset d_norm", 64'(d_norm), 64'd0);
    check("reset shift", 64'(shift_amount), 64'd0);
    check("reset zero", 64'(zero), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_gap(1);

    // Directed table; gap 0 starts the next op in the done cycle (back-to-back).
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].a, vecs[i].v, vecs[i].en, vecs[i].es, vecs[i].ez, vecs[i].el,
            $sformatf("vec%0d", i));
      idle_gap(vecs[i].gap);
    end

    // A second start while busy must be ignored and outputs must hold.
    start = 1'b1; arith = 1'b0; d = 32'h0000_0100;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3 || i == 4) begin
        start = 1'b1; d = 32'h0000_0001; arith = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (i == 4) begin
        check("busyprot busy", 64'(busy), 64'd1);
        check("busyprot d_norm held", 64'(d_norm), 64'(prev_norm));
        check("busyprot shift held", 64'(shift_amount), 64'(prev_shift));
      end
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    check("busyprot latency", 64'(lat), 64'd24);
    check("busyprot shift", 64'(shift_amount), 64'd23);
    check("busyprot d_norm", 64'(d_norm), 64'h8000_0000);
    prev_norm = 32'h8000_0000; prev_shift = 23; prev_zero = 1'b0;
    idle_gap(1);

    // Reset mid-operation: asynchronous clear, no done pulse, clean restart.
    start = 1'b1; arith = 1'b0; d = 32'h0000_0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst d_norm", 64'(d_norm), 64'd0);
    check("midrst shift", 64'(shift_amount), 64'd0);
    check("midrst zero", 64'(zero), 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("midrst no done", 64'(done), 64'd0);
    end
    rst = 1'b0;
    prev_norm = '0; prev_shift = 0; prev_zero = 1'b0;
    idle_gap(3);
    do_op(1'b0, 32'h0000_0001, 32'h8000_0000, 31, 1'b0, 32, "after_rst");
    idle_gap(1);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic        a;
      logic [31:0] v;
      a = 1'($urandom_range(0, 1));
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) v = ~v;
      if ($urandom_range(0, 15) == 0) v = '0;
      model(a, v, rn, rs, rz, rl);
      do_op(a, v, rn, rs, rz, rl, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) idle_gap(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
